// File: rtl/i2s_rx_master.sv
// i2s_rx_master: I2S master receiver for the microphone path.
// Generates SCK (i2s_clk) and word select from HCLK, deserialises Philips-format
// serial data (one-bit delay after the ws edge, MSB first) into per-channel PCM
// samples, and buffers them in a first-word-fall-through FIFO with valid/ready.
// Optional build macro: I2S_RX_MONO_EN -- push only left-slot samples and tie
// sample_chan to 0. Without it both channels are pushed, left then right.
module i2s_rx_master #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned SAMPLE_BITS = 24,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic                             en,
    input  logic                             sd_in,
    output logic                             i2s_clk,
    output logic                             ws,
    output logic [SAMPLE_BITS-1:0]           sample_data,
    output logic                             sample_chan,
    output logic                             sample_valid,
    input  logic                             sample_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             overflow,
    input  logic                             clr_ovf
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);

    localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [4:0]      SlotLast = 5'd31;
    localparam logic [4:0]      CapLast  = 5'(SAMPLE_BITS);
    localparam logic [LvlW-1:0] LvlFull  = LvlW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // SCK divider
    // ------------------------------------------------------------------
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            sck_q, sck_d;
    logic            tick, rise, fall;

    assign tick = en && (div_cnt_q == DivLast);
    assign rise = tick && !sck_q;
    assign fall = tick && sck_q;

    // Divider next state: held at zero while disabled, toggles SCK on wrap.
    always_comb begin
        div_cnt_d = div_cnt_q;
        sck_d     = sck_q;
        if (!en) begin
            div_cnt_d = '0;
            sck_d     = 1'b0;
        end else if (tick) begin
            div_cnt_d = '0;
            sck_d     = !sck_q;
        end else begin
            div_cnt_d = div_cnt_q + DivW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Framing: 32 SCK per slot, ws flips on the fall that wraps bit_cnt
    // ------------------------------------------------------------------
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic       ws_q, ws_d;

    // Slot bit counter and word select next state, advanced on SCK falls.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        ws_d      = ws_q;
        if (!en) begin
            bit_cnt_d = '0;
            ws_d      = 1'b0;
        end else if (fall) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == SlotLast) begin
                ws_d = !ws_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture: bit_cnt 1 carries the MSB, bit_cnt SAMPLE_BITS the LSB
    // ------------------------------------------------------------------
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic [SAMPLE_BITS-1:0] cap_word;
    logic                   cap_en, cap_last;
    logic                   push_req;

    assign cap_en   = rise && (bit_cnt_q != 5'd0) && (bit_cnt_q <= CapLast);
    assign cap_last = rise && (bit_cnt_q == CapLast);
    // The completed word includes the bit being sampled this cycle.
    assign cap_word = SAMPLE_BITS'({shift_q, sd_in});

    // Shift register next state; cleared while disabled so a partial word dies.
    always_comb begin
        shift_d = shift_q;
        if (!en) begin
            shift_d = '0;
        end else if (cap_en) begin
            shift_d = cap_word;
        end
    end

`ifdef I2S_RX_MONO_EN
    assign push_req = cap_last && !ws_q;
`else
    assign push_req = cap_last;
`endif

    // Front-end state registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
            bit_cnt_q <= '0;
            ws_q      <= 1'b0;
            shift_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
            bit_cnt_q <= bit_cnt_d;
            ws_q      <= ws_d;
            shift_q   <= shift_d;
        end
    end

    assign i2s_clk = sck_q;
    assign ws      = ws_q;

    // ------------------------------------------------------------------
    // Sample FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [SAMPLE_BITS-1:0] data_mem [FIFO_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]        level_q, level_d;
    logic                   empty, full, pop, accept, drop;
    logic                   ovf_q, ovf_d;

    assign empty  = (level_q == '0);
    assign full   = (level_q == LvlFull);
    assign pop    = !empty && sample_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign accept = push_req && (!full || pop);
    assign drop   = push_req && full && !pop;

    // Occupancy next state.
    always_comb begin
        level_d = level_q;
        unique case ({accept, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    // Sticky overflow next state; a drop beats a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // FIFO pointers, occupancy and overflow flag; pointers wrap naturally.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    // Sample storage; contents are meaningless once the level says empty.
    always_ff @(posedge HCLK) begin
        if (accept) begin
            data_mem[wr_ptr_q] <= cap_word;
        end
    end

`ifdef I2S_RX_MONO_EN
    assign sample_chan = 1'b0;
`else
    logic chan_mem [FIFO_DEPTH];

    // Channel tag storage, written alongside the sample.
    always_ff @(posedge HCLK) begin
        if (accept) begin
            chan_mem[wr_ptr_q] <= ws_q;
        end
    end

    assign sample_chan = empty ? 1'b0 : chan_mem[rd_ptr_q];
`endif

    assign sample_data  = empty ? '0 : data_mem[rd_ptr_q];
    assign sample_valid = !empty;
    assign fifo_level   = level_q;
    assign overflow     = ovf_q;

endmodule
